// File: rtl/pio_in_capture_pkg.sv
// Shared definitions for the pio_in_capture Avalon-MM input port: register map,
// CTRL/FIFO_STATUS field positions and the edge-detect helper.
package pio_in_capture_pkg;

  localparam logic [2:0] ADDR_DATA        = 3'd0;
  localparam logic [2:0] ADDR_IRQ_MASK    = 3'd1;
  localparam logic [2:0] ADDR_EDGE_CAP    = 3'd2;
  localparam logic [2:0] ADDR_FIFO_DATA   = 3'd3;
  localparam logic [2:0] ADDR_FIFO_STATUS = 3'd4;
  localparam logic [2:0] ADDR_CTRL        = 3'd5;

  typedef enum logic [1:0] {
    EM_RISE = 2'b00,
    EM_FALL = 2'b01,
    EM_ANY  = 2'b10,
    EM_OFF  = 2'b11
  } edge_mode_e;

  localparam int CTRL_FIFO_EN     = 0;
  localparam int CTRL_FLUSH       = 1;
  localparam int CTRL_EM_LO       = 2;
  localparam int CTRL_EM_HI       = 3;
  localparam int CTRL_FIFO_IRQ_EN = 4;

  localparam int ST_EMPTY    = 0;
  localparam int ST_FULL     = 1;
  localparam int ST_OVERFLOW = 2;
  localparam int ST_COUNT_LO = 8;

  function automatic logic [31:0] edge_detect(input edge_mode_e mode,
                                              input logic [31:0] prev,
                                              input logic [31:0] cur);
    logic [31:0] res;
    case (mode)
      EM_RISE: res = ~prev & cur;
      EM_FALL: res = prev & ~cur;
      EM_ANY:  res = prev ^ cur;
      EM_OFF:  res = 32'd0;
      default: res = 32'd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/pio_in_capture_sync_fifo.sv
// Single-clock FIFO with a combinational head output; a pop on a full FIFO
// frees the slot for a push on the same edge, and flush wins over push/pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign empty = (count_q == {(AW+1){1'b0}});
  assign full  = (count_q == CNT_FULL);
  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

  // Next-state for storage, pointers and occupancy
  always_comb begin
    mem_d     = mem_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    do_pop_s  = pop & ~empty;
    do_push_s = push & (~full | do_pop_s);
    if (flush) begin
      rd_ptr_d = {AW{1'b0}};
      wr_ptr_d = {AW{1'b0}};
      count_d  = {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {WIDTH{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      wr_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/pio_in_capture.sv
// Avalon-MM input port: synchronised input bus with per-bit edge capture,
// interrupt masking and a change-recording FIFO for software polling.
module pio_in_capture
  import pio_in_capture_pkg::*;
#(
  parameter int         WIDTH         = 8,
  parameter int         DEPTH         = 16,
  parameter int         SYNC_STAGES   = 2,
  parameter logic [1:0] EDGE_MODE_RST = 2'b00
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(SYNC_STAGES + 2);
  localparam logic [PW-1:0] PRIME_MAX = PW'(SYNC_STAGES + 1);
  localparam logic [PW-1:0] PRIME_ONE = PW'(1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [PW-1:0]    prime_cnt_q, prime_cnt_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic             ovf_q, ovf_d;
  logic             fifo_en_q, fifo_en_d;
  edge_mode_e       edge_mode_q, edge_mode_d;
  logic             fifo_irq_en_q, fifo_irq_en_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;

  logic [WIDTH-1:0] s_s, edges_s, w1c_s, fifo_dout_s;
  logic [31:0]      edge_word_s;
  logic             primed_s, change_s, push_s, pop_s, flush_s, wr_s;
  logic             fifo_empty_s, fifo_full_s;
  logic [AW:0]      fifo_count_s;
  logic             unused_wdata_s;

  assign readdata       = readdata_q;
  assign irq            = irq_q;
  assign unused_wdata_s = ^writedata;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_s),
    .pop     (pop_s),
    .flush   (flush_s),
    .din     (s_s),
    .dout    (fifo_dout_s),
    .empty   (fifo_empty_s),
    .full    (fifo_full_s),
    .count   (fifo_count_s)
  );

  // Event detection, register updates, read mux and interrupt
  always_comb begin
    s_s         = sync_q[SYNC_STAGES-1];
    sync_d      = {sync_q[SYNC_STAGES-2:0], in_port};
    prev_d      = s_s;
    primed_s    = (prime_cnt_q == PRIME_MAX);
    prime_cnt_d = primed_s ? prime_cnt_q : prime_cnt_q + PRIME_ONE;
    wr_s        = chipselect & write;
    change_s    = primed_s & (s_s != prev_q);
    push_s      = fifo_en_q & change_s;
    pop_s       = chipselect & read & (address == ADDR_FIFO_DATA);
    flush_s     = wr_s & (address == ADDR_CTRL) & writedata[CTRL_FLUSH];
    edge_word_s = edge_detect(edge_mode_q, 32'(prev_q), 32'(s_s));
    edges_s     = primed_s ? edge_word_s[WIDTH-1:0] : {WIDTH{1'b0}};
    w1c_s       = (wr_s & (address == ADDR_EDGE_CAP)) ? writedata[WIDTH-1:0] : {WIDTH{1'b0}};
    // A new edge beats a same-cycle W1C on that bit
    edge_cap_d  = (edge_cap_q & ~w1c_s) | edges_s;

    mask_d        = mask_q;
    fifo_en_d     = fifo_en_q;
    edge_mode_d   = edge_mode_q;
    fifo_irq_en_d = fifo_irq_en_q;
    if (wr_s && address == ADDR_IRQ_MASK) begin
      mask_d = writedata[WIDTH-1:0];
    end else if (wr_s && address == ADDR_CTRL) begin
      fifo_en_d     = writedata[CTRL_FIFO_EN];
      edge_mode_d   = edge_mode_e'(writedata[CTRL_EM_HI:CTRL_EM_LO]);
      fifo_irq_en_d = writedata[CTRL_FIFO_IRQ_EN];
    end else begin
      mask_d = mask_q;
    end

    ovf_d = ovf_q;
    if (push_s && fifo_full_s && !pop_s && !flush_s) begin
      ovf_d = 1'b1;
    end else if (wr_s && address == ADDR_FIFO_STATUS && writedata[ST_OVERFLOW]) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    readdata_d = 32'd0;
    case (address)
      ADDR_DATA:      readdata_d[WIDTH-1:0] = s_s;
      ADDR_IRQ_MASK:  readdata_d[WIDTH-1:0] = mask_q;
      ADDR_EDGE_CAP:  readdata_d[WIDTH-1:0] = edge_cap_q;
      ADDR_FIFO_DATA: readdata_d[WIDTH-1:0] = fifo_empty_s ? {WIDTH{1'b0}} : fifo_dout_s;
      ADDR_FIFO_STATUS: begin
        readdata_d[ST_EMPTY]                 = fifo_empty_s;
        readdata_d[ST_FULL]                  = fifo_full_s;
        readdata_d[ST_OVERFLOW]              = ovf_q;
        readdata_d[ST_COUNT_LO +: AW+1]      = fifo_count_s;
      end
      ADDR_CTRL: begin
        readdata_d[CTRL_FIFO_EN]             = fifo_en_q;
        readdata_d[CTRL_EM_HI:CTRL_EM_LO]    = edge_mode_q;
        readdata_d[CTRL_FIFO_IRQ_EN]         = fifo_irq_en_q;
      end
      default: readdata_d = 32'd0;
    endcase

    irq_d = (|(edge_cap_q & mask_q)) | (fifo_irq_en_q & (~fifo_empty_s | ovf_q));
  end

  // Architectural state, all reset asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q        <= '0;
      prev_q        <= {WIDTH{1'b0}};
      prime_cnt_q   <= {PW{1'b0}};
      mask_q        <= {WIDTH{1'b0}};
      edge_cap_q    <= {WIDTH{1'b0}};
      ovf_q         <= 1'b0;
      fifo_en_q     <= 1'b0;
      edge_mode_q   <= edge_mode_e'(EDGE_MODE_RST);
      fifo_irq_en_q <= 1'b0;
      readdata_q    <= 32'd0;
      irq_q         <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      prev_q        <= prev_d;
      prime_cnt_q   <= prime_cnt_d;
      mask_q        <= mask_d;
      edge_cap_q    <= edge_cap_d;
      ovf_q         <= ovf_d;
      fifo_en_q     <= fifo_en_d;
      edge_mode_q   <= edge_mode_d;
      fifo_irq_en_q <= fifo_irq_en_d;
      readdata_q    <= readdata_d;
      irq_q         <= irq_d;
    end
  end

endmodule
